// File: rtl/drowsiness_alarm.sv
// Drowsiness alarm: per-frame argmax classifier with a confidence gate, followed by a hysteresis FSM
// that raises, escalates, holds and clears the driver alarm. DROWSY_EVENT_COUNTER_EN enables event_count_o.
module drowsiness_alarm #(
    parameter int unsigned DW       = 10,
    parameter int unsigned CONF_TH  = 600,
    parameter int unsigned ALERT_N  = 4,
    parameter int unsigned CLEAR_N  = 8,
    parameter int unsigned HOLD_CYC = 1024,
    parameter int unsigned CW       = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                frame_valid_i,
    input  logic [2:0][DW-1:0]  ann_in_i,
    input  logic                ack_i,
    output logic [1:0]          class_out_o,
    output logic                class_valid_o,
    output logic                alarm_o,
    output logic [1:0]          alarm_level_o,
    output logic [15:0]         event_count_o
);

    localparam logic [1:0] S_MONITOR = 2'd0;
    localparam logic [1:0] S_ARMING  = 2'd1;
    localparam logic [1:0] S_ALARM   = 2'd2;

    localparam logic [DW-1:0] CONF_W  = DW'(CONF_TH);
    localparam logic [CW-1:0] ALERT_W = CW'(ALERT_N);
    localparam logic [CW-1:0] CLEAR_W = CW'(CLEAR_N);
    localparam logic [CW-1:0] HOLD_W  = CW'(HOLD_CYC);

    logic [1:0]    win_cls, cls_d, class_q;
    logic [DW-1:0] win_score;
    logic          class_valid_q;

    // Ties go to the higher (more severe) class index.
    always_comb begin
        if (ann_in_i[2] >= ann_in_i[1] && ann_in_i[2] >= ann_in_i[0]) begin
            win_cls   = 2'd2;
            win_score = ann_in_i[2];
        end else if (ann_in_i[1] >= ann_in_i[0]) begin
            win_cls   = 2'd1;
            win_score = ann_in_i[1];
        end else begin
            win_cls   = 2'd0;
            win_score = ann_in_i[0];
        end
        cls_d = (win_score < CONF_W) ? 2'd3 : win_cls;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            class_q       <= 2'd0;
            class_valid_q <= 1'b0;
        end else begin
            class_valid_q <= frame_valid_i;
            if (frame_valid_i) class_q <= cls_d;
        end
    end

    logic [1:0]    state_q, state_d, level_q, level_d;
    logic [CW-1:0] run_q, run_d, hold_q, hold_d, clr_q, clr_d, run_inc;
    logic          severe, calm, exit_ok, entry;

    assign severe  = class_valid_q && (class_q == 2'd1 || class_q == 2'd2);
    assign calm    = class_valid_q && (class_q == 2'd0);
    assign exit_ok = (hold_q == HOLD_W) && ((clr_q == CLEAR_W) || ack_i);
    assign run_inc = run_q + CW'(1);

    always_comb begin
        // NOTE: every next-state signal defaults to its register first, so no path can infer a latch.
        state_d = state_q;
        level_d = level_q;
        run_d   = run_q;
        hold_d  = hold_q;
        clr_d   = clr_q;
        entry   = 1'b0;
        case (state_q)
            S_MONITOR, S_ARMING: begin
                if (severe) begin
                    run_d = run_inc;
                    if (run_inc >= ALERT_W) entry = 1'b1;
                    else                    state_d = S_ARMING;
                end else if (calm) begin
                    run_d   = '0;
                    state_d = S_MONITOR;
                end
            end
            S_ALARM: begin
                // A frame arriving together with the exit is dropped, not counted toward a new run.
                if (exit_ok) begin
                    state_d = S_MONITOR;
                    level_d = 2'd0;
                    run_d   = '0;
                    clr_d   = '0;
                    hold_d  = '0;
                end else begin
                    if (hold_q != HOLD_W) hold_d = hold_q + CW'(1);
                    if (severe) begin
                        clr_d = '0;
                        if (class_q == 2'd2) level_d = 2'd2;
                    end else if (calm && clr_q != CLEAR_W) begin
                        clr_d = clr_q + CW'(1);
                    end
                end
            end
            default: state_d = S_MONITOR;
        endcase
        if (entry) begin
            state_d = S_ALARM;
            hold_d  = '0;
            clr_d   = '0;
            level_d = (class_q == 2'd2) ? 2'd2 : 2'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_MONITOR;
            level_q <= 2'd0;
            run_q   <= '0;
            hold_q  <= '0;
            clr_q   <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            run_q   <= run_d;
            hold_q  <= hold_d;
            clr_q   <= clr_d;
        end
    end

`ifdef DROWSY_EVENT_COUNTER_EN
    logic [15:0] evt_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                          evt_q <= 16'd0;
        else if (entry && evt_q != 16'hFFFF) evt_q <= evt_q + 16'd1;
    end
    assign event_count_o = evt_q;
`else
    assign event_count_o = 16'd0;
`endif

    assign class_out_o   = class_q;
    assign class_valid_o = class_valid_q;
    assign alarm_o       = (state_q == S_ALARM);
    assign alarm_level_o = level_q;

endmodule

// File: tb/tb_drowsiness_alarm.sv
// Self-checking bench for drowsiness_alarm: classifier vector table, hand-written alarm sequences,
// and randomized traffic compared against a frame-level reference model.
module tb_drowsiness_alarm;

    localparam int DW = 10, CONF_TH = 600, ALERT_N = 4, CLEAR_N = 8, HOLD_CYC = 16, CW = 16;
`ifdef DROWSY_EVENT_COUNTER_EN
    localparam int EVT_ON = 1;
`else
    localparam int EVT_ON = 0;
`endif

    logic               clk_i = 1'b0, rst_i = 1'b0, frame_valid_i = 1'b0, ack_i = 1'b0;
    logic [2:0][DW-1:0] ann_in_i = '0;
    logic [1:0]         class_out_o, alarm_level_o;
    logic               class_valid_o, alarm_o;
    logic [15:0]        event_count_o;

    drowsiness_alarm #(.DW(DW), .CONF_TH(CONF_TH), .ALERT_N(ALERT_N), .CLEAR_N(CLEAR_N),
                       .HOLD_CYC(HOLD_CYC), .CW(CW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .frame_valid_i(frame_valid_i), .ann_in_i(ann_in_i),
        .ack_i(ack_i), .class_out_o(class_out_o), .class_valid_o(class_valid_o),
        .alarm_o(alarm_o), .alarm_level_o(alarm_level_o), .event_count_o(event_count_o));

    always #5 clk_i = ~clk_i;

    int n_checks = 0, n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: frame-level rules expressed with plain integers.
    int m_cv, m_cls, m_alarm, m_level, m_run, m_hold, m_clr, m_events;

    function automatic int ref_classify(input int a0, input int a1, input int a2);
        int s[3];
        int best;
        s[0] = a0; s[1] = a1; s[2] = a2;
        best = 0;
        for (int k = 1; k < 3; k++) if (s[k] >= s[best]) best = k;
        return (s[best] < CONF_TH) ? 3 : best;
    endfunction

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_cv = 0; m_cls = 0; m_alarm = 0; m_level = 0;
            m_run = 0; m_hold = 0; m_clr = 0; m_events = 0;
        end else begin
            if (m_alarm != 0) begin
                if (m_hold == HOLD_CYC && (m_clr == CLEAR_N || ack_i)) begin
                    m_alarm = 0; m_level = 0; m_run = 0; m_clr = 0;
                end else begin
                    if (m_hold < HOLD_CYC) m_hold++;
                    if (m_cv != 0 && m_cls == 0) begin
                        if (m_clr < CLEAR_N) m_clr++;
                    end else if (m_cv != 0 && (m_cls == 1 || m_cls == 2)) begin
                        m_clr = 0;
                        if (m_cls == 2) m_level = 2;
                    end
                end
            end else if (m_cv != 0 && m_cls == 0) begin
                m_run = 0;
            end else if (m_cv != 0 && m_cls != 3) begin
                m_run++;
                if (m_run >= ALERT_N) begin
                    m_alarm = 1; m_hold = 0; m_clr = 0; m_level = m_cls;
                    if (EVT_ON != 0 && m_events < 65535) m_events++;
                end
            end
            m_cv = frame_valid_i ? 1 : 0;
            if (frame_valid_i)
                m_cls = ref_classify(int'(ann_in_i[0]), int'(ann_in_i[1]), int'(ann_in_i[2]));
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic set_frame(input int a0, input int a1, input int a2);
        ann_in_i[0] = DW'(a0);
        ann_in_i[1] = DW'(a1);
        ann_in_i[2] = DW'(a2);
        frame_valid_i = 1'b1;
    endtask

    task automatic send(input int a0, input int a1, input int a2);
        set_frame(a0, a1, a2);
        step();
        frame_valid_i = 1'b0;
    endtask

    task automatic do_reset();
        frame_valid_i = 1'b0;
        ack_i = 1'b0;
        rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
    endtask

    typedef struct {
        int a0, a1, a2;
        int exp_cls;
    } vec_t;

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{100, 800, 50, 1};
        vecs[1]  = '{900, 50, 50, 0};
        vecs[2]  = '{500, 550, 400, 3};
        vecs[3]  = '{0, 0, 700, 2};
        vecs[4]  = '{700, 700, 0, 1};
        vecs[5]  = '{700, 0, 700, 2};
        vecs[6]  = '{650, 650, 650, 2};
        vecs[7]  = '{600, 0, 0, 0};
        vecs[8]  = '{599, 0, 0, 3};
        vecs[9]  = '{0, 599, 599, 3};
        vecs[10] = '{1000, 999, 0, 0};
        vecs[11] = '{0, 1023, 1023, 2};

        // Reset state
        do_reset();
        check("reset class_out", int'(class_out_o), 0);
        check("reset class_valid", int'(class_valid_o), 0);
        check("reset alarm", int'(alarm_o), 0);
        check("reset alarm_level", int'(alarm_level_o), 0);
        check("reset event_count", int'(event_count_o), 0);

        // Classifier table
        foreach (vecs[i]) begin
            send(vecs[i].a0, vecs[i].a1, vecs[i].a2);
            check($sformatf("vec[%0d] class_out", i), int'(class_out_o), vecs[i].exp_cls);
            check($sformatf("vec[%0d] class_valid", i), int'(class_valid_o), 1);
        end

        // Raise, escalate, clear after hold
        do_reset();
        set_frame(100, 800, 50);
        for (int k = 0; k < 4; k++) begin
            step();
            check("raise class_out", int'(class_out_o), 1);
        end
        frame_valid_i = 1'b0;
        check("raise alarm before latency", int'(alarm_o), 0);
        step();
        check("raise alarm", int'(alarm_o), 1);
        check("raise level", int'(alarm_level_o), 1);
        check("raise event_count", int'(event_count_o), EVT_ON);
        send(0, 0, 700);
        step();
        check("escalate level", int'(alarm_level_o), 2);
        for (int k = 0; k < 8; k++) send(900, 50, 50);
        check("awake before hold alarm", int'(alarm_o), 1);
        check("awake keeps level", int'(alarm_level_o), 2);
        idle(6);
        check("alarm at hold expiry", int'(alarm_o), 1);
        step();
        check("alarm cleared", int'(alarm_o), 0);
        check("level cleared", int'(alarm_level_o), 0);

        // ack ignored before hold, honoured after; simultaneous frame dropped
        do_reset();
        set_frame(100, 800, 50);
        idle(4);
        frame_valid_i = 1'b0;
        step();
        check("ack seq alarm up", int'(alarm_o), 1);
        idle(5);
        ack_i = 1'b1;
        step();
        ack_i = 1'b0;
        check("early ack ignored", int'(alarm_o), 1);
        idle(9);
        check("alarm held no clear", int'(alarm_o), 1);
        send(100, 800, 50);
        check("alarm at hold 16", int'(alarm_o), 1);
        ack_i = 1'b1;
        step();
        ack_i = 1'b0;
        check("ack exit", int'(alarm_o), 0);
        set_frame(100, 800, 50);
        idle(3);
        frame_valid_i = 1'b0;
        idle(2);
        check("exit frame dropped", int'(alarm_o), 0);
        send(100, 800, 50);
        step();
        check("re-raise after exit", int'(alarm_o), 1);
        check("event_count two raises", int'(event_count_o), 2 * EVT_ON);

        // Awake frame resets arming
        do_reset();
        set_frame(100, 800, 50);
        idle(3);
        set_frame(900, 50, 50);
        step();
        set_frame(100, 800, 50);
        idle(3);
        frame_valid_i = 1'b0;
        idle(3);
        check("arming reset by awake", int'(alarm_o), 0);
        send(100, 800, 50);
        step();
        check("run of 4 after reset", int'(alarm_o), 1);

        // Uncertain frame does not break the run
        do_reset();
        set_frame(100, 800, 50);
        idle(2);
        set_frame(500, 550, 400);
        step();
        check("uncertain class_out", int'(class_out_o), 3);
        set_frame(100, 800, 50);
        idle(2);
        frame_valid_i = 1'b0;
        check("uncertain run pending", int'(alarm_o), 0);
        step();
        check("uncertain run raises", int'(alarm_o), 1);
        check("uncertain run level", int'(alarm_level_o), 1);

        // Async reset mid-arming
        do_reset();
        set_frame(100, 800, 50);
        idle(2);
        frame_valid_i = 1'b0;
        #2;
        rst_i = 1'b1;
        #1;
        check("async rst class_out", int'(class_out_o), 0);
        check("async rst class_valid", int'(class_valid_o), 0);
        check("async rst alarm", int'(alarm_o), 0);
        step();
        rst_i = 1'b0;
        set_frame(100, 800, 50);
        idle(3);
        frame_valid_i = 1'b0;
        idle(3);
        check("run cleared by rst", int'(alarm_o), 0);

        // Randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int kind;
            bit awake_phase;
            awake_phase = ((i / 250) % 2) == 1;
            if ($urandom_range(0, 9) < 6) begin
                kind = $urandom_range(0, 5);
                if (awake_phase && kind < 4) kind = 0;
                case (kind)
                    0, 1: set_frame($urandom_range(650, 1023), $urandom_range(0, 640), $urandom_range(0, 640));
                    2, 3: set_frame($urandom_range(0, 640), $urandom_range(650, 1023), $urandom_range(0, 640));
                    4:    set_frame($urandom_range(0, 640), $urandom_range(0, 640), $urandom_range(650, 1023));
                    default: set_frame($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023));
                endcase
            end else begin
                frame_valid_i = 1'b0;
            end
            ack_i = ($urandom_range(0, 19) == 0);
            step();
            check($sformatf("rand[%0d] class_out", i), int'(class_out_o), m_cls);
            check($sformatf("rand[%0d] class_valid", i), int'(class_valid_o), m_cv);
            check($sformatf("rand[%0d] alarm", i), int'(alarm_o), m_alarm);
            check($sformatf("rand[%0d] alarm_level", i), int'(alarm_level_o), m_level);
            check($sformatf("rand[%0d] event_count", i), int'(event_count_o), m_events);
        end
        frame_valid_i = 1'b0;
        ack_i = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/drowsiness_alarm.md
# drowsiness_alarm

Downstream consumer of the drowsiness detector's ANN output stage. Per completed inference it takes the three activation scores, picks the winning class, and rejects low-confidence frames. It then runs a hysteresis state machine over consecutive frames to raise, escalate, hold and clear a driver alarm. Its outputs drive the buzzer/LED interface and the host status register.

## Interface
Parameters:
- DW, 10, score width; scores are unsigned fixed-point with 1000 = 1.0
- CONF_TH, 600, minimum winning score for a frame to count
- ALERT_N, 4, consecutive drowsy/asleep frames required to raise the alarm (≥1)
- CLEAR_N, 8, consecutive awake frames required to clear the alarm (≥1)
- HOLD_CYC, 1024, minimum alarm duration in clock cycles (≥1)
- CW, 16, width of run/hold counters

Ports:
- Clock  in  1  system clock, all state on rising edge
- Rst  in  1  reset, asynchronous, active-high
- frame_valid  in  1  one-cycle pulse; ann_in valid this cycle
- ann_in[2:0]  in  DW each  class scores: [0] awake, [1] drowsy, [2] asleep
- ack  in  1  operator acknowledge, level-sampled
- class_out  out  2  last classified frame: 0 awake, 1 drowsy, 2 asleep, 3 uncertain
- class_valid  out  1  one-cycle pulse, class_out updated
- alarm  out  1  alarm active
- alarm_level  out  2  0 none, 1 warning (drowsy), 2 critical (asleep)
- event_count  out  16  number of alarm entries since reset

## Operation
- Stage 1 (classify): on frame_valid, argmax over ann_in; ties resolve to the higher index (more severe). If the winning score < CONF_TH, class = 3. The result is registered into class_out, and class_valid pulses.
- Stage 2 (FSM): consumes class_out when class_valid = 1. Uncertain frames (3) change no counter and no state.
- MONITOR: alarm=0, alarm_level=0, run_cnt=0.
  - Class 1 or 2 → run_cnt=1. Go to ALARM if ALERT_N==1, else ARMING.
- ARMING: alarm=0.
  - Class 1/2 → run_cnt+1; reaching ALERT_N → ALARM.
  - Class 0 → run_cnt=0, MONITOR.
- ALARM entry: hold_cnt=0, clr_cnt=0. alarm_level=2 if the triggering frame is class 2, else 1. event_count+1.
- ALARM:
  - hold_cnt increments every cycle and saturates at HOLD_CYC.
  - Class 2 → level=2. Level never de-escalates inside ALARM.
  - Class 1/2 → clr_cnt=0.
  - Class 0 → clr_cnt+1, saturating at CLEAR_N.
  - Exit to MONITOR when hold_cnt==HOLD_CYC and (clr_cnt==CLEAR_N or ack==1). Exit clears alarm, level, run_cnt and clr_cnt.
- ack in MONITOR/ARMING, or before hold expires, is ignored and not remembered.
- ack and a class 1/2 frame in the same cycle after hold expiry: the exit wins. The frame is dropped, not counted toward a new run.
- frame_valid while a previous frame is in stage 1: each frame_valid is processed. At most one frame per cycle; back-to-back pulses are supported.

## Timing
- Reset values: class_out=0, class_valid=0, alarm=0, alarm_level=0, event_count=0, state=MONITOR, all counters 0. Reset takes effect immediately (async) and aborts any frame in flight.
- frame_valid at edge N → class_out/class_valid at N+1 → FSM and alarm/alarm_level/event_count update at N+2.
- Raise latency: ALARM asserts 2 cycles after the frame_valid of the ALERT_N-th consecutive drowsy/asleep frame.
- Clear: alarm deasserts the cycle after the exit condition first holds. Minimum alarm width is HOLD_CYC+1 cycles.
- Counters saturate; none wraps.

## Configuration
- DROWSY_EVENT_COUNTER_EN defined: event_count is a 16-bit saturating counter (stops at 65535) of MONITOR/ARMING→ALARM transitions.
- DROWSY_EVENT_COUNTER_EN undefined: no counter logic; event_count is tied to 0.

## Test plan
Bench parameters: ALERT_N=4, CLEAR_N=8, HOLD_CYC=16.
- Scores {100,800,50} ×4 frames, 1 cycle apart → class_out=1 each; alarm=1, level=1 two cycles after the 4th frame_valid; event_count=1.
- 3 drowsy frames, then {900,50,50}, then 3 drowsy → ARMING resets; alarm stays 0.
- Scores {500,550,400} (winner below 600) between drowsy frames → class_out=3; run continues; 4 drowsy + 1 uncertain still raises the alarm.
- In ALARM at level 1: one frame {0,0,700} → level=2. Next, 8 awake frames with hold not yet expired → alarm stays high until hold_cnt=16, then drops.
- ack at hold_cnt=5 → ignored. ack after hold_cnt=16 → alarm=0 next cycle.
- Ties {700,700,0} → class 1. Rst pulsed mid-ARMING → all outputs 0 immediately. With DROWSY_EVENT_COUNTER_EN undefined → event_count=0 after any number of alarms.
